pll_seq: RTL and testbench
==========================

// Module: pll_seq
// PURPOSE
//  Power-up/recovery sequencer that drives the control pins of the PLL wrapper
//  (pllen, resetn, clkout0en..clkout3en) and consumes its lock output.
//  Holds the PLL in reset, waits for a stable lock, then enables the selected
//  output clocks one at a time. On lock loss it gates the outputs and retries;
//  after MAX_RETRY consecutive failures it parks in FAULT.
//  Clocked by the free-running board reference clock, the same clock that
//  feeds PLL clkin.
// PARAMETERS
//  CNT_W         16       width of the shared cycle counter
//  RST_CYCLES    16       cycles PLL resetn is held low per attempt (>=1)
//  LOCK_TIMEOUT  50000    max cycles in WAIT_LOCK before an attempt fails (< 2**CNT_W)
//  STABLE_CYCLES 1024     consecutive synced-lock-high cycles required (< 2**CNT_W)
//  CLKEN_MASK    4'b0011  output clocks to enable; bit n drives clkouten[n]
//  MAX_RETRY     3        failed attempts tolerated before FAULT (1..15)
// PORTS
//  clk         in   1   reference clock
//  reset       in   1   synchronous, active-high reset
//  enable      in   1   level; 1 = bring the PLL up and keep it up
//  lock        in   1   PLL lock, asynchronous; 2-flop synchronised inside as lock_s
//  pllen       out  1   to PLL pllen
//  pll_resetn  out  1   to PLL resetn, active low
//  clkouten    out  4   to PLL clkout3en..clkout0en
//  ready       out  1   1 only in RUN
//  fault       out  1   1 only in FAULT
//  state       out  3   current state encoding, for debug
// BEHAVIOUR
//  - All outputs are registered. On reset: state=OFF, pllen=0, pll_resetn=0,
//    clkouten=0, ready=0, fault=0, counter=0, retry count=0, sync flops=0.
//  - lock_s lags lock by 2 clk.
//  - States (encoding): OFF=0, RESET=1, WAIT_LOCK=2, STABLE=3, ENABLE=4, RUN=5, FAULT=6.
//  - OFF: pllen=0, pll_resetn=0. enable=1 -> RESET with counter=0.
//  - RESET: pllen=1, pll_resetn=0 for exactly RST_CYCLES cycles
//    -> WAIT_LOCK with counter=0.
//  - WAIT_LOCK: pll_resetn=1.
//    - lock_s=1 -> STABLE with counter=0.
//    - counter reaches LOCK_TIMEOUT-1 -> attempt fails.
//  - STABLE: counter counts cycles with lock_s=1.
//    - STABLE_CYCLES reached -> ENABLE.
//    - lock_s=0 -> WAIT_LOCK with counter=0. No retry is consumed, but the
//      timeout counter restarts.
//  - ENABLE: on each cycle, set the lowest bit of CLKEN_MASK not yet set in
//    clkouten (one bit per cycle). Once clkouten==CLKEN_MASK -> RUN.
//    CLKEN_MASK=0 -> RUN after 1 cycle.
//  - RUN: ready=1; retry count clears on entry. lock_s=0 -> attempt fails.
//  - Attempt fails (WAIT_LOCK timeout or RUN lock loss):
//    - next cycle: clkouten=0, ready=0, pll_resetn=0, retry count +1;
//    - new count == MAX_RETRY -> FAULT, otherwise -> RESET with counter=0.
//  - FAULT: pllen=0, pll_resetn=0, clkouten=0, fault=1. Leaves only via
//    enable=0 -> OFF.
//  - enable=0 in any state -> OFF next cycle: clkouten=0, pllen=0,
//    pll_resetn=0, retry count=0. This overrides every other transition in
//    the same cycle, including a timeout.
//  - Reset asserted mid-sequence -> OFF state and outputs on the next edge,
//    no partial enables left set.
//  - Counter saturates; it never wraps.
// TESTING (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CLKEN_MASK=4'b0101, MAX_RETRY=2)
//  1. enable=1, lock rises 5 cycles after pll_resetn=1 and stays high
//     -> pll_resetn low exactly 4 cycles; clkouten 0000->0001->0101 on
//        successive cycles; ready=1 after clkouten=0101.
//  2. lock never rises -> two 20-cycle WAIT_LOCK windows separated by a
//     4-cycle RESET, then fault=1, pllen=0.
//     Then enable=0 -> state=OFF, fault=0 next cycle.
//  3. In RUN, drop lock for 1 cycle -> 2 cycles later clkouten=0, ready=0,
//     state=RESET; lock returns -> ready=1 again, no fault.
//  4. lock glitches low at STABLE cycle 6 -> state=WAIT_LOCK, stable count
//     restarts, fault stays 0.
//  5. enable=0 during ENABLE with clkouten=0001 -> next cycle clkouten=0,
//     pllen=0, state=OFF.
//  6. reset pulse during STABLE -> all outputs at reset values; restart
//     re-runs the full RESET phase.

Source files
------------

// File: rtl/pll_seq.sv
// rtl/pll_seq.sv - PLL power-up/recovery sequencer driving pllen, resetn and clock enables
module pll_seq #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter logic [3:0]  CLKEN_MASK    = 4'b0011,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lock,
    output logic       pllen,
    output logic       pll_resetn,
    output logic [3:0] clkouten,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_ENABLE    = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

    state_t           cur;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       retry;
    logic [3:0]       retry_nxt;
    logic             lock_m;
    logic             lock_s;
    logic [3:0]       need;
    logic [3:0]       next_bit;
    logic             fail_now;

    assign state     = cur;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign retry_nxt = retry + 4'd1;

    // lowest mask bit still missing from clkouten
    assign need     = CLKEN_MASK & ~clkouten;
    assign next_bit = need & (~need + 4'd1);

    assign fail_now = enable && !lock_s &&
                      ((cur == S_RUN) || (cur == S_WAIT_LOCK && cnt == TIMEOUT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_OFF;
            cnt        <= '0;
            retry      <= '0;
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            pllen      <= 1'b0;
            pll_resetn <= 1'b0;
            clkouten   <= '0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
            if (!enable) begin
                cur        <= S_OFF;
                cnt        <= '0;
                retry      <= '0;
                pllen      <= 1'b0;
                pll_resetn <= 1'b0;
                clkouten   <= '0;
                ready      <= 1'b0;
                fault      <= 1'b0;
            end else if (fail_now) begin
                clkouten   <= '0;
                ready      <= 1'b0;
                pll_resetn <= 1'b0;
                retry      <= retry_nxt;
                cnt        <= '0;
                if (retry_nxt == RETRY_LIMIT) begin
                    cur   <= S_FAULT;
                    pllen <= 1'b0;
                    fault <= 1'b1;
                end else begin
                    cur   <= S_RESET;
                    pllen <= 1'b1;
                end
            end else begin
                case (cur)
                    S_OFF: begin
                        cur        <= S_RESET;
                        cnt        <= '0;
                        pllen      <= 1'b1;
                        pll_resetn <= 1'b0;
                    end
                    S_RESET: begin
                        if (cnt == RST_LAST) begin
                            cur        <= S_WAIT_LOCK;
                            cnt        <= '0;
                            pll_resetn <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s) begin
                            cur <= S_STABLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_STABLE: begin
                        // a lock drop here only restarts the lock wait, no retry charged
                        if (!lock_s) begin
                            cur <= S_WAIT_LOCK;
                            cnt <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            cur <= S_ENABLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_ENABLE: begin
                        if (clkouten == CLKEN_MASK) begin
                            cur   <= S_RUN;
                            ready <= 1'b1;
                            retry <= '0;
                        end else begin
                            clkouten <= clkouten | next_bit;
                        end
                    end
                    S_RUN, S_FAULT: begin
                    end
                    default: begin
                        cur        <= S_OFF;
                        cnt        <= '0;
                        pllen      <= 1'b0;
                        pll_resetn <= 1'b0;
                        clkouten   <= '0;
                        ready      <= 1'b0;
                        fault      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_seq.sv
// tb/tb_pll_seq.sv - self-checking bench for pll_seq against a phase-level model
module tb_pll_seq;

    localparam int         RST  = 4;
    localparam int         TO   = 20;
    localparam int         ST   = 8;
    localparam logic [3:0] MASK = 4'b0101;
    localparam int         MAXR = 2;

    localparam int OFF = 0, RS = 1, WL = 2, STB = 3, EN = 4, RUN = 5, FLT = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       lock = 1'b0;
    logic       pllen, pll_resetn, ready, fault;
    logic [3:0] clkouten;
    logic [2:0] state;

    pll_seq #(
        .CNT_W(16), .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
        .CLKEN_MASK(MASK), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .lock(lock),
        .pllen(pllen), .pll_resetn(pll_resetn), .clkouten(clkouten),
        .ready(ready), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: phase, time spent in phase, failed attempts, clocks enabled so far
    int m_state = OFF, m_el = 0, m_fails = 0, m_on = 0, m_nxt;
    bit m_ls1 = 0, m_ls2 = 0, m_valid = 0, m_failed;
    int mask_bits;
    initial mask_bits = $countones(MASK);

    function automatic logic [3:0] first_bits(input int n);
        logic [3:0] msk = MASK;
        logic [3:0] r = 4'b0;
        int k = 0;
        for (int b = 0; b < 4; b++)
            if (msk[b] && k < n) begin r[b] = 1'b1; k++; end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state = OFF; m_el = 0; m_fails = 0; m_on = 0;
            m_ls1 = 0; m_ls2 = 0; m_valid = 1;
        end else begin
            m_nxt = m_state; m_failed = 0;
            if (!enable) begin
                m_nxt = OFF; m_fails = 0;
            end else begin
                case (m_state)
                    OFF: m_nxt = RS;
                    RS:  if (m_el + 1 == RST) m_nxt = WL;
                    WL:  if (m_ls2) m_nxt = STB; else if (m_el + 1 == TO) m_failed = 1;
                    STB: if (!m_ls2) m_nxt = WL; else if (m_el + 1 == ST) m_nxt = EN;
                    EN:  if (m_on == mask_bits) begin m_nxt = RUN; m_fails = 0; end
                    RUN: if (!m_ls2) m_failed = 1;
                    default: ;
                endcase
            end
            if (m_failed) begin
                m_fails++;
                m_nxt = (m_fails == MAXR) ? FLT : RS;
            end
            if (m_nxt != m_state || m_failed) m_el = 0; else m_el++;
            if (m_state == EN && m_nxt == EN) m_on++;
            if (m_nxt != EN && m_nxt != RUN) m_on = 0;
            m_state = m_nxt;
            m_ls2 = m_ls1; m_ls1 = lock;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state", int'(state), m_state);
            chk("m_pllen", int'(pllen), int'(m_state >= RS && m_state <= RUN));
            chk("m_resetn", int'(pll_resetn), int'(m_state >= WL && m_state <= RUN));
            chk("m_clkouten", int'(clkouten),
                int'((m_state == EN || m_state == RUN) ? first_bits(m_on) : 4'b0));
            chk("m_ready", int'(ready), int'(m_state == RUN));
            chk("m_fault", int'(fault), int'(m_state == FLT));
        end
    end

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(state) != s && n < budget) begin @(negedge clk); n++; end
        chk(name, int'(state), s);
    endtask

    task automatic dwell(input int s, input int budget, output int n);
        n = 0;
        while (int'(state) == s && n < budget) begin @(negedge clk); n++; end
    endtask

    task automatic count_reset_low(output int n);
        n = 0;
        for (int i = 0; i < 50 && pll_resetn !== 1'b1; i++) begin
            @(negedge clk);
            if (pllen && !pll_resetn) n++;
        end
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk(name, int'(ready), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pllen"}, int'(pllen), 0);
        chk({tag, "_resetn"}, int'(pll_resetn), 0);
        chk({tag, "_clkouten"}, int'(clkouten), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        // 1: clean bring-up
        reset = 1'b0; enable = 1'b1;
        count_reset_low(n);
        chk("t1_resetn_low_cycles", n, 4);
        repeat (5) @(negedge clk);
        lock = 1'b1;
        n = 0;
        while (clkouten == 4'b0 && n < 60) begin @(negedge clk); n++; end
        chk("t1_clk_first", int'(clkouten), 1);
        @(negedge clk);
        chk("t1_clk_second", int'(clkouten), 5);
        chk("t1_ready_late", int'(ready), 0);
        @(negedge clk);
        chk("t1_ready", int'(ready), 1);
        chk("t1_run", int'(state), RUN);

        // 3: one-cycle lock drop in RUN
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        wait_state(RS, 10, "t3_to_reset");
        chk("t3_clk_off", int'(clkouten), 0);
        chk("t3_ready_off", int'(ready), 0);
        wait_ready(100, "t3_recover");
        chk("t3_no_fault", int'(fault), 0);

        // 4: lock glitch during STABLE
        enable = 1'b0; lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_off", int'(state), OFF);
        enable = 1'b1;
        wait_state(WL, 10, "t4_wait1");
        lock = 1'b1;
        wait_state(STB, 10, "t4_stable1");
        repeat (3) @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        wait_state(WL, 10, "t4_back_to_wait");
        chk("t4_no_fault", int'(fault), 0);
        wait_state(STB, 10, "t4_stable2");
        dwell(STB, 50, n);
        chk("t4_stable_len", n, 8);

        // 5: enable drop mid-ENABLE
        n = 0;
        while (clkouten != 4'b0001 && n < 5) begin @(negedge clk); n++; end
        chk("t5_partial", int'(clkouten), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_clk_off", int'(clkouten), 0);
        chk("t5_pllen_off", int'(pllen), 0);
        chk("t5_state_off", int'(state), OFF);

        // 2: lock never arrives
        lock = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_state(WL, 10, "t2_wait1");
        dwell(WL, 40, n);
        chk("t2_wait1_len", n, 20);
        chk("t2_retry_reset", int'(state), RS);
        dwell(RS, 10, n);
        chk("t2_reset_len", n, 4);
        dwell(WL, 40, n);
        chk("t2_wait2_len", n, 20);
        chk("t2_fault_state", int'(state), FLT);
        chk("t2_fault", int'(fault), 1);
        chk("t2_pllen", int'(pllen), 0);
        repeat (3) @(negedge clk);
        chk("t2_fault_held", int'(state), FLT);
        enable = 1'b0;
        @(negedge clk);
        chk("t2_off", int'(state), OFF);
        chk("t2_fault_clr", int'(fault), 0);

        // 6: reset pulse during STABLE
        lock = 1'b1; enable = 1'b1;
        wait_state(STB, 40, "t6_stable");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6");
        reset = 1'b0;
        count_reset_low(n);
        chk("t6_resetn_low_cycles", n, 4);
        wait_ready(100, "t6_ready");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
